// File: rtl/wave_buf_reader_if.sv
// Video in/out and waveform-buffer read port bundle for wave_buf_reader.
// The slave modport is the reader's view; master is the view of the surrounding video/buffer logic.
interface wave_buf_reader_if;
  logic        i_hs;
  logic        i_vs;
  logic        i_de;
  logic [23:0] i_data;
  logic [11:0] buf_rd_addr;
  logic [7:0]  buf_rd_data;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic [23:0] o_data;
  logic        frame_start;

  modport slave (
    input  i_hs, i_vs, i_de, i_data, buf_rd_data,
    output buf_rd_addr, o_hs, o_vs, o_de, o_data, frame_start
  );

  modport master (
    output i_hs, i_vs, i_de, i_data, buf_rd_data,
    input  buf_rd_addr, o_hs, o_vs, o_de, o_data, frame_start
  );
endinterface

// File: rtl/wave_buf_reader.sv
// Waveform buffer reader: walks the sample buffer with the video raster and overlays a connected trace.
// Optional macro WAVE_GRID_EN adds a grid drawn under the trace inside the window.
module wave_buf_reader #(
  parameter int unsigned WAVE_X0    = 128,
  parameter int unsigned WAVE_Y0    = 232,
  parameter int unsigned WAVE_W     = 1024,
  parameter int unsigned WAVE_H     = 256,
  parameter logic [23:0] WAVE_COLOR = 24'hFFFF00,
  parameter logic [23:0] GRID_COLOR = 24'h404040
) (
  input  logic             video_clk,
  input  logic             rst_n,
  wave_buf_reader_if.slave bus
);

  localparam int          DATA_W = 24;
  localparam logic [12:0] X_LO   = 13'(WAVE_X0);
  localparam logic [12:0] X_HI   = 13'(WAVE_X0 + WAVE_W);
  localparam logic [12:0] Y_LO   = 13'(WAVE_Y0);
  localparam logic [12:0] Y_HI   = 13'(WAVE_Y0 + WAVE_H);
  localparam logic [11:0] X0_12  = 12'(WAVE_X0);
  localparam logic [11:0] Y0_12  = 12'(WAVE_Y0);

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_RUN     = 2'd1
  } state_t;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic in_span(input logic [7:0] r, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (r >= lo) && (r <= hi);
  endfunction

  state_t              r_state;
  logic                r_frame_start;
  logic                r_vs_d;
  logic                r_de_d;
  logic [11:0]         r_x;
  logic [11:0]         r_y;
  logic [11:0]         r_addr;

  logic                r_vld_p1;
  logic                r_first_p1;
  logic                r_hs_p1;
  logic                r_vs_p1;
  logic                r_de_p1;
  logic [7:0]          r_row_p1;
  logic [DATA_W-1:0]   r_data_p1;
  logic [7:0]          r_prev;

  logic                r_hs_p2;
  logic                r_vs_p2;
  logic                r_de_p2;
  logic [DATA_W-1:0]   r_data_p2;

  logic                w_vs_rise;
  logic                w_de_fall;
  logic                w_in_win;
  logic [11:0]         w_col;
  logic [7:0]          w_row;
  logic [7:0]          w_level;
  logic [7:0]          w_prev;
  logic                w_lit;
  logic                w_grid;

  assign w_vs_rise = bus.i_vs & ~r_vs_d;
  assign w_de_fall = ~bus.i_de & r_de_d;
  assign w_col     = r_x - X0_12;
  assign w_row     = 8'(r_y - Y0_12);
  assign w_in_win  = (r_state == S_RUN) && bus.i_de
                     && ({1'b0, r_x} >= X_LO) && ({1'b0, r_x} < X_HI)
                     && ({1'b0, r_y} >= Y_LO) && ({1'b0, r_y} < Y_HI);

  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      r_state       <= S_WAIT_VS;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        S_WAIT_VS: if (w_vs_rise) r_state <= S_RUN;
        S_RUN:     r_frame_start <= w_vs_rise;
        default:   r_state <= S_WAIT_VS;
      endcase
    end
  end

  // Raster counters: x is the column within the DE run, y the DE line since the last VS rise.
  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_x    <= 12'd0;
      r_y    <= 12'd0;
    end else begin
      r_vs_d <= bus.i_vs;
      r_de_d <= bus.i_de;
      if ((r_state == S_WAIT_VS) && w_vs_rise) r_x <= 12'd0;
      else if (bus.i_de)                       r_x <= sat_inc12(r_x);
      else if (w_de_fall)                      r_x <= 12'd0;
      if (w_vs_rise)      r_y <= 12'd0;
      else if (w_de_fall) r_y <= sat_inc12(r_y);
    end
  end

  // Stage 0: address issue; outside the window the last in-window address is held.
  always_ff @(posedge video_clk) begin
    if (!rst_n)        r_addr <= 12'd0;
    else if (w_in_win) r_addr <= w_col;
  end

  assign bus.buf_rd_addr = w_in_win ? w_col : r_addr;

  // Stage 1: sideband travels with the read; buf_rd_data arrives during this stage.
  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_first_p1 <= 1'b0;
      r_hs_p1    <= 1'b0;
      r_vs_p1    <= 1'b0;
      r_de_p1    <= 1'b0;
    end else begin
      r_vld_p1   <= w_in_win;
      r_first_p1 <= (r_x == X0_12);
      r_hs_p1    <= bus.i_hs;
      r_vs_p1    <= bus.i_vs;
      r_de_p1    <= bus.i_de;
    end
  end

  always_ff @(posedge video_clk) begin
    r_row_p1  <= w_row;
    r_data_p1 <= bus.i_data;
  end

  assign w_level = 8'd255 - bus.buf_rd_data;
  assign w_prev  = r_first_p1 ? w_level : r_prev;
  assign w_lit   = r_vld_p1 && in_span(r_row_p1, w_prev, w_level);

  always_ff @(posedge video_clk) begin
    if (!rst_n)        r_prev <= 8'd0;
    else if (r_vld_p1) r_prev <= w_level;
  end

`ifdef WAVE_GRID_EN
  logic r_gcol_p1;

  always_ff @(posedge video_clk) begin
    r_gcol_p1 <= (w_col[6:0] == 7'd0);
  end

  assign w_grid = r_vld_p1 && !w_lit
                  && (r_gcol_p1 || (r_row_p1[5:0] == 6'd0) || (r_row_p1 == 8'hFF));
`else
  assign w_grid = 1'b0;
`endif

  // Stage 2: registered outputs, trace over grid over pass-through video.
  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      r_hs_p2   <= 1'b0;
      r_vs_p2   <= 1'b0;
      r_de_p2   <= 1'b0;
      r_data_p2 <= '0;
    end else begin
      r_hs_p2   <= r_hs_p1;
      r_vs_p2   <= r_vs_p1;
      r_de_p2   <= r_de_p1;
      r_data_p2 <= w_lit ? WAVE_COLOR : (w_grid ? GRID_COLOR : r_data_p1);
    end
  end

  assign bus.o_hs        = r_hs_p2;
  assign bus.o_vs        = r_vs_p2;
  assign bus.o_de        = r_de_p2;
  assign bus.o_data      = r_data_p2;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_wave_buf_reader.sv
// Testbench for wave_buf_reader: reduced raster (2-column offset, 8-sample window, 256-row window).
// Scoreboard of expected outputs per driven pixel plus hand-computed spot checks per buffer pattern.
module tb_wave_buf_reader;
  localparam int X0  = 2;
  localparam int Y0  = 3;
  localparam int W   = 8;
  localparam int NL  = Y0 + 256 + 2;
  localparam int ACT = 12;
  localparam int BL  = 4;
  localparam logic [23:0] WC = 24'hFFFF00;
  localparam logic [23:0] GC = 24'h404040;

  logic video_clk = 1'b0;
  logic rst_n     = 1'b0;
  always #5 video_clk = ~video_clk;

  wave_buf_reader_if bus ();

  wave_buf_reader #(
    .WAVE_X0(X0), .WAVE_Y0(Y0), .WAVE_W(W), .WAVE_H(256),
    .WAVE_COLOR(WC), .GRID_COLOR(GC)
  ) dut (
    .video_clk(video_clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [7:0] mem [0:1023];
  always @(posedge video_clk) bus.buf_rd_data <= mem[bus.buf_rd_addr[9:0]];

  int fs_total = 0;
  always @(negedge video_clk) if (bus.frame_start === 1'b1) fs_total++;

  typedef struct {
    logic hs; logic vs; logic de; logic [23:0] data; int line; int col;
  } exp_t;

  typedef struct { int pat; int line; int col; bit lit; } vec_t;

  exp_t        q[$];
  vec_t        vt[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [23:0] cap_out [0:NL-1][0:ACT-1];
  logic [23:0] cap_in  [0:NL-1][0:ACT-1];
  bit          model_run = 0;
  logic [11:0] exp_addr = '0;
  bit          prev_vs = 0;

  function automatic logic [23:0] model_pix(int line, int col, logic [23:0] din);
    int r, k, lev, pv, lo, hi;
    r   = line - Y0;
    k   = col - X0;
    lev = 255 - int'(mem[k]);
    pv  = (k == 0) ? lev : 255 - int'(mem[k-1]);
    lo  = (pv < lev) ? pv : lev;
    hi  = (pv < lev) ? lev : pv;
    if (r >= lo && r <= hi) return WC;
`ifdef WAVE_GRID_EN
    if ((k % 128) == 0 || (r % 64) == 0 || r == 255) return GC;
`endif
    return din;
  endfunction

  task automatic check_out();
    exp_t e;
    if (q.size() >= 2) begin
      e = q.pop_front();
      n_chk++;
      if ({bus.o_hs, bus.o_vs, bus.o_de, bus.o_data} !== {e.hs, e.vs, e.de, e.data}) begin
        n_fail++;
        $display("FAIL pix line %0d col %0d: got hs=%0b vs=%0b de=%0b data=%06h, want hs=%0b vs=%0b de=%0b data=%06h",
                 e.line, e.col, bus.o_hs, bus.o_vs, bus.o_de, bus.o_data, e.hs, e.vs, e.de, e.data);
      end
      if (e.line >= 0) cap_out[e.line][e.col] = bus.o_data;
    end
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de,
                       input logic [23:0] d, input int line, input int col);
    exp_t e;
    bit   in_w;
    @(negedge video_clk);
    check_out();
    rst_n      = 1'b1;
    bus.i_hs   = hs;
    bus.i_vs   = vs;
    bus.i_de   = de;
    bus.i_data = d;
    in_w = model_run && de && line >= Y0 && line < Y0 + 256 && col >= X0 && col < X0 + W;
    if (in_w) exp_addr = 12'(col - X0);
    e.hs = hs; e.vs = vs; e.de = de;
    e.data = in_w ? model_pix(line, col, d) : d;
    e.line = (de && line >= 0) ? line : -1;
    e.col  = col;
    q.push_back(e);
    if (de && line >= 0) cap_in[line][col] = d;
    if (vs && !prev_vs) model_run = 1;
    prev_vs = vs;
    #1;
    n_chk++;
    if (bus.buf_rd_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL addr line %0d col %0d: got %0d, want %0d", line, col, bus.buf_rd_addr, exp_addr);
    end
  endtask

  task automatic apply_reset(input int n);
    exp_t z;
    z = '{hs: 1'b0, vs: 1'b0, de: 1'b0, data: 24'h0, line: -1, col: -1};
    for (int i = 0; i < n; i++) begin
      @(negedge video_clk);
      check_out();
      rst_n = 1'b0;
      bus.i_hs = 1'b0; bus.i_vs = 1'b0; bus.i_de = 1'b0; bus.i_data = 24'h0;
      for (int j = 0; j < q.size(); j++) q[j] = z;
      q.push_back(z);
      model_run = 0;
      exp_addr  = '0;
      prev_vs   = 0;
      if (i > 0) begin
        #1;
        n_chk++;
        if (bus.buf_rd_addr !== 12'd0 || bus.frame_start !== 1'b0 || bus.o_data !== 24'h0) begin
          n_fail++;
          $display("FAIL reset state: got addr=%0d fs=%0b data=%06h, want 0 0 000000",
                   bus.buf_rd_addr, bus.frame_start, bus.o_data);
        end
      end
    end
  endtask

  task automatic run_frame(input int act, input int rst_line, input int exp_fs);
    int fs0;
    fs0 = fs_total;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 24'($urandom), -1, -1);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 24'($urandom), -1, -1);
    for (int l = 0; l < NL; l++) begin
      if (l == rst_line) apply_reset(4);
      for (int c = 0; c < act; c++) drive(1'b0, 1'b0, 1'b1, 24'($urandom), l, c);
      for (int b = 0; b < BL; b++) drive(b < 2, 1'b0, 1'b0, 24'($urandom), -1, -1);
    end
    n_chk++;
    if (fs_total - fs0 != exp_fs) begin
      n_fail++;
      $display("FAIL frame_start count: got %0d, want %0d", fs_total - fs0, exp_fs);
    end
  endtask

  task automatic check_table(input int pat);
    logic [23:0] want;
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].pat == pat) begin
        want = vt[i].lit ? WC : cap_in[vt[i].line][vt[i].col];
        n_chk++;
        if (cap_out[vt[i].line][vt[i].col] !== want) begin
          n_fail++;
          $display("FAIL spot pat%0d line %0d col %0d: got %06h, want %06h",
                   pat, vt[i].line, vt[i].col, cap_out[vt[i].line][vt[i].col], want);
        end
      end
    end
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < 1024; k++) begin
      case (pat)
        0:       mem[k] = 8'd128;
        1:       mem[k] = (k < W / 2) ? 8'd0 : 8'd255;
        default: mem[k] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  initial begin
    // pattern 0: flat 128 -> level 127 -> line Y0+127 = 130, cols X0..X0+W-1 = 2..9
    vt.push_back('{0, 130, 2, 1});  vt.push_back('{0, 130, 5, 1});
    vt.push_back('{0, 130, 9, 1});  vt.push_back('{0, 129, 5, 0});
    vt.push_back('{0, 131, 5, 0});  vt.push_back('{0, 130, 1, 0});
    vt.push_back('{0, 130, 10, 0});
    // pattern 1: step 0 then 255 -> line 258 cols 2..5, col 6 spans 3..258, line 3 cols 7..9
    vt.push_back('{1, 258, 2, 1});  vt.push_back('{1, 258, 5, 1});
    vt.push_back('{1, 258, 6, 1});  vt.push_back('{1, 3, 6, 1});
    vt.push_back('{1, 100, 6, 1});  vt.push_back('{1, 3, 7, 1});
    vt.push_back('{1, 3, 9, 1});    vt.push_back('{1, 100, 5, 0});
    vt.push_back('{1, 3, 5, 0});    vt.push_back('{1, 258, 7, 0});
    vt.push_back('{1, 259, 6, 0});  vt.push_back('{1, 2, 6, 0});

    bus.i_hs = 1'b0; bus.i_vs = 1'b0; bus.i_de = 1'b0; bus.i_data = 24'h0;
    fill(0);
    apply_reset(4);

    for (int c = 0; c < ACT; c++) drive(1'b0, 1'b0, 1'b1, 24'($urandom), -1, c);
    for (int b = 0; b < BL; b++)  drive(b < 2, 1'b0, 1'b0, 24'($urandom), -1, -1);

    run_frame(ACT, -1, 0);
    run_frame(ACT, -1, 1);
    check_table(0);

    fill(1);
    run_frame(ACT, -1, 1);
    check_table(1);
    run_frame(X0 + W, -1, 1);
    check_table(1);

    fill(2);
    run_frame(ACT, 100, 1);

    fill(0);
    run_frame(ACT, -1, 0);
    check_table(0);

    fill(2);
    run_frame(ACT, -1, 1);

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'h0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
